// File: rtl/robm_action_queue_pkg.sv
// ============================================================================
// Module   : robm_action_pkg
// Purpose  : Shared action-vector type and bit-index constants for robm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package robm_action_pkg;

    localparam int ACT_W = 10;

    typedef logic [ACT_W-1:0] act_t;

    localparam int ACT_Y1  = 0;
    localparam int ACT_Y2  = 1;
    localparam int ACT_Y3  = 2;
    localparam int ACT_Y4  = 3;
    localparam int ACT_Y5  = 4;
    localparam int ACT_Y6  = 5;
    localparam int ACT_Y7  = 6;
    localparam int ACT_Y8  = 7;
    localparam int ACT_Y9  = 8;
    localparam int ACT_Y10 = 9;

    localparam act_t ACT_IDLE = '0;

endpackage

`default_nettype wire

// File: rtl/robm_action_queue_if.sv
// ============================================================================
// Module   : robm_action_queue_if
// Purpose  : Controller/actuator bus of the action queue (slave = queue side).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface robm_action_queue_if #(
    parameter int DEPTH = 8
);
    import robm_action_pkg::*;

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    act_t               y_in;
    act_t               act_data;
    logic               act_valid;
    logic               act_ready;
    logic [c_CNT_W-1:0] count;
    logic               ovf;
    logic               ovf_clr;

    modport master (
        output y_in, act_ready, ovf_clr,
        input  act_data, act_valid, count, ovf
    );

    modport slave (
        input  y_in, act_ready, ovf_clr,
        output act_data, act_valid, count, ovf
    );

endinterface

`default_nettype wire

// File: rtl/robm_action_fifo_core.sv
// ============================================================================
// Module   : robm_action_fifo_core
// Purpose  : Count-based FIFO storage, pointers and push/pop acceptance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module robm_action_fifo_core #(
    parameter int DEPTH = 8,
    parameter int DW    = 10
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic                     pop_req,
    input  wire logic [DW-1:0]            wdata,
    output logic      [DW-1:0]            rdata,
    output logic                          valid,
    output logic      [$clog2(DEPTH):0]   count,
    output logic                          push_acc
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [DW-1:0]      r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push_acc;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL);
    assign w_pop      = !w_empty && pop_req;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign w_push_acc = push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_acc)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_push_acc && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push_acc)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && w_push_acc)
            r_mem[r_wr_ptr] <= wdata;
    end

    assign rdata    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign valid    = !w_empty;
    assign count    = r_count;
    assign push_acc = w_push_acc;

endmodule

`default_nettype wire

// File: rtl/robm_action_queue.sv
// ============================================================================
// Module   : robm_action_queue
// Purpose  : Captures non-zero robm action vectors into a FIFO toward the
//            actuator; sticky overflow flag. Option macro: ACT_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module robm_action_queue
    import robm_action_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  wire logic           clk,
    input  wire logic           rst,
    robm_action_queue_if.slave  bus
);

    logic w_push_req;
    logic w_push;
    logic w_push_acc;
    logic r_ovf;

    assign w_push_req = (bus.y_in != ACT_IDLE);

`ifdef ACT_COALESCE_EN
    act_t r_last;
    logic r_prev_nz;
    logic w_suppress;

    // A repeat of the last stored vector is one action held over several cycles.
    assign w_suppress = r_prev_nz && (bus.y_in == r_last);
    assign w_push     = w_push_req && !w_suppress;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last    <= ACT_IDLE;
            r_prev_nz <= 1'b0;
        end else begin
            r_prev_nz <= w_push_req;
            if (w_push_acc)
                r_last <= bus.y_in;
        end
    end
`else
    assign w_push = w_push_req;
`endif

    robm_action_fifo_core #(
        .DEPTH (DEPTH),
        .DW    (ACT_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pop_req  (bus.act_ready),
        .wdata    (bus.y_in),
        .rdata    (bus.act_data),
        .valid    (bus.act_valid),
        .count    (bus.count),
        .push_acc (w_push_acc)
    );

    always_ff @(posedge clk) begin
        if (!rst)
            r_ovf <= 1'b0;
        else if (w_push && !w_push_acc)
            r_ovf <= 1'b1;
        else if (bus.ovf_clr)
            r_ovf <= 1'b0;
    end

    assign bus.ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_robm_action_queue.sv
// ============================================================================
// Module   : tb_robm_action_queue
// Purpose  : Randomized scoreboard bench for robm_action_queue with a
//            queue-based reference model. Honours ACT_COALESCE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_robm_action_queue;
    import robm_action_pkg::*;

    localparam int c_DEPTH = 8;
`ifdef ACT_COALESCE_EN
    localparam bit c_COAL = 1'b1;
`else
    localparam bit c_COAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    robm_action_queue_if #(.DEPTH(c_DEPTH)) bus ();

    robm_action_queue #(.DEPTH(c_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;

    act_t sb[$];
    int   m_count  = 0;
    bit   m_ovf    = 1'b0;
    act_t m_last   = '0;
    bit   m_prev   = 1'b0;
    bit   m_known  = 1'b0;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        check_int("count", int'(bus.count), m_count);
        check_int("act_valid", int'(bus.act_valid), (m_count != 0) ? 1 : 0);
        check_int("ovf", int'(bus.ovf), int'(m_ovf));
        if (m_count == 0)
            check_int("act_data_idle", int'(bus.act_data), 0);
    endtask

    // Reference behaviour of one rising edge, evaluated from pre-edge state.
    task automatic model_edge(input act_t y, input logic rdy, input logic clr, input logic rn);
        bit pop, req, push, acc;
        if (!rn) begin
            sb.delete();
            m_count = 0;
            m_ovf   = 1'b0;
            m_last  = '0;
            m_prev  = 1'b0;
            m_known = 1'b1;
        end else begin
            pop  = (m_count != 0) && rdy;
            req  = (y != 0);
            push = req && !(c_COAL && m_prev && (y == m_last));
            acc  = push && ((m_count < c_DEPTH) || pop);
            if (push && !acc)
                m_ovf = 1'b1;
            else if (clr)
                m_ovf = 1'b0;
            if (acc) begin
                sb.push_back(y);
                m_last = y;
            end
            m_prev  = req;
            m_count = m_count + (acc ? 1 : 0) - (pop ? 1 : 0);
        end
    endtask

    task automatic step(input act_t y, input logic rdy, input logic clr, input logic rn);
        @(negedge clk);
        if (m_known)
            check_state();
        bus.y_in      = y;
        bus.act_ready = rn ? rdy : 1'b0;
        bus.ovf_clr   = clr;
        rst           = rn;
        model_edge(y, bus.act_ready, clr, rn);
    endtask

    // Monitor: every accepted head is compared with the scoreboard front.
    initial begin
        act_t exp;
        forever begin
            @(negedge clk);
            #1;
            if (rst && bus.act_valid && bus.act_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL pop_empty: actual=%h required=no_pop at %0t", bus.act_data, $time);
                end else begin
                    exp = sb.pop_front();
                    if (bus.act_data !== exp) begin
                        failures++;
                        $display("FAIL pop_data: actual=%h required=%h at %0t", bus.act_data, exp, $time);
                    end
                end
            end
        end
    end

    initial begin
        act_t ry;
        act_t prev_y;
        int   pr;
        bus.y_in      = '0;
        bus.act_ready = 1'b0;
        bus.ovf_clr   = 1'b0;

        step('0, 0, 0, 0);
        step('0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step('0, 0, 0, 1);

        step(10'h008, 0, 0, 1);
        step(10'h003, 0, 0, 1);
        step(10'h006, 0, 0, 1);
        for (int i = 0; i < 5; i++) step('0, 1, 0, 1);

        // Overfill, push through a full queue, then exercise ovf_clr priority.
        for (int i = 0; i < 9; i++) step(act_t'(i + 16), 0, 0, 1);
        step(10'h200, 1, 0, 1);
        step(10'h201, 0, 1, 1);
        step('0, 0, 1, 1);
        for (int i = 0; i < 10; i++) step('0, 1, 0, 1);

        for (int i = 0; i < 20; i++) step(act_t'(i + 100), 1, 0, 1);
        for (int i = 0; i < 3; i++) step('0, 1, 0, 1);

        step(10'h010, 0, 0, 1);
        step(10'h010, 0, 0, 1);
        step('0, 0, 0, 1);
        step(10'h010, 0, 0, 1);
        step('0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step('0, 1, 0, 1);

        for (int i = 0; i < 5; i++) step(act_t'(i + 40), 0, 0, 1);
        step('0, 0, 0, 0);
        step('0, 0, 0, 1);

        prev_y = '0;
        pr     = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0)
                pr = (i % 300 == 0) ? 20 : ((i % 300 == 100) ? 90 : 50);
            case ($urandom_range(0, 3))
                0:       ry = '0;
                1:       ry = prev_y;
                default: ry = act_t'($urandom_range(1, 1023));
            endcase
            prev_y = ry;
            step(ry, ($urandom_range(0, 99) < pr), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 199) != 0));
        end
        step('0, 1, 0, 1);
        @(negedge clk);
        check_state();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/robm_action_queue.md
# robm_action_queue

Downstream capture stage for the `robm` controller. Every clock in which the controller drives a non-zero action vector (y1..y10), this block stores that vector in order in a small FIFO. The FIFO drains to an actuator interface through a valid/ready handshake. Actions issued while the actuator is busy are therefore never lost, and overflow is flagged rather than silently dropped.

## Interface
- `DEPTH`, 8 — FIFO entries; power of two, ≥2.
- `ACT_W`, 10 — action vector width; bit 0 = y1 … bit 9 = y10.
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — reset, synchronous, active-low (`rst`=0 on a rising `clk` edge resets).
- `y_in`  in  ACT_W  — controller action vector; sampled on rising `clk`.
- `act_data`  out  ACT_W  — head-of-queue action.
- `act_valid`  out  1  — `act_data` holds a queued action.
- `act_ready`  in  1  — actuator accepts head this cycle.
- `count`  out  $clog2(DEPTH)+1  — current occupancy.
- `ovf`  out  1  — sticky overflow flag.
- `ovf_clr`  in  1  — clears `ovf`.

## Operation
- Push request: `push_req = (y_in != 0)`. An all-zero vector is idle and is never stored.
- Pop: `pop = act_valid & act_ready`.
- Push accepted when `count < DEPTH`, or when `count == DEPTH` and `pop` is asserted in the same cycle.
- Push request refused when full with no pop. In that case:
  - Set `ovf`; the refused vector is discarded.
  - Queue contents are unchanged.
- Simultaneous push and pop:
  - `count` is unchanged.
  - Both pointers advance.
  - Allowed at every occupancy, including empty with `act_valid`=0; in that case no pop occurs, so only the push happens.
- Pointers are `$clog2(DEPTH)` bits wide and wrap modulo DEPTH; full/empty are decided from `count`, not from pointer equality.
- `act_data` = storage[rd_ptr]. It is 0 whenever `act_valid`=0, never stale data.
- `act_valid` = (`count` != 0).
- `ovf`: same-cycle `ovf_clr` and a new overflow → set wins. Otherwise `ovf_clr` clears it.
- Reset values: `count`=0, pointers=0, `act_valid`=0, `act_data`=0, `ovf`=0. Storage contents need not be cleared.
- Reset mid-operation discards all queued actions and any concurrent push or pop.

## Timing
- Push-to-visible latency: 1 cycle. A vector pushed at edge N appears on `act_data`/`act_valid` after edge N.
- Pop takes effect at the edge where `pop`=1; the next entry is visible after that edge.
- `act_valid`, `act_data`, `count` and `ovf` are register-driven or decoded from registers only. They have no combinational path from `y_in` or `act_ready`.
- `y_in` settles within the half cycle after the controller's falling-edge state update. It must be stable at the rising edge.
- Throughput: one push and one pop per cycle sustained.

## Configuration
- `ACT_COALESCE_EN` defined:
  - A push request whose vector equals the last accepted vector is suppressed, provided no idle (zero) cycle came in between.
  - The last-accepted register and a "previous cycle was non-zero" flag reset to 0.
  - A suppressed request neither consumes space nor sets `ovf`.
  - A refused request (overflow) does not update the last-accepted register.
- `ACT_COALESCE_EN` undefined: every non-zero cycle is a distinct push. The comparison logic is absent.

## Structure
- Package `robm_action_pkg`:
  - `ACT_W` = 10.
  - `act_t` (logic [ACT_W-1:0]).
  - Bit-index constants `ACT_Y1`..`ACT_Y10` (0..9).
  - `ACT_IDLE` = '0.
- Sub-module `robm_action_fifo_core`: storage, pointers, `count`, full/empty, push/pop acceptance.
- Top level: push-request generation, optional coalescing, `ovf` logic, output gating.

## Test plan
- Reset, then `y_in`=0 for 5 cycles → `count`=0, `act_valid`=0, `act_data`=0, `ovf`=0.
- `act_ready`=0; push 10'h008, 10'h003, 10'h006 on consecutive cycles → `count`=3. Then raise `act_ready` → `act_data` shows 008, 003, 006 on successive cycles, then `act_valid`=0.
- `act_ready`=0, DEPTH=8; push 9 distinct vectors → `count`=8, `ovf`=1, first 8 retained in order. A push with `act_ready`=1 while full → accepted, `count` stays 8, `ovf` unchanged.
- Continuous push and pop for 20 cycles → `count` stays 1 and each output equals the vector pushed one cycle earlier, confirming pointer wrap.
- `ovf`=1, `ovf_clr`=1 with an overflowing push in the same cycle → `ovf` stays 1. The next cycle with `ovf_clr`=1 and no overflow → `ovf`=0.
- Coalescing:
  - With `ACT_COALESCE_EN`: `y_in` = 010,010,000,010 → 2 entries.
  - Without it: 3 entries.
  - Separately, `rst`=0 with `count`=5 → `count`=0 and `act_valid`=0 after that edge.
